vga_number_scheduler: RTL

//  Scan controller and time-multiplexer for the shared VGA hex-number renderer. Generates 640x480
//  VGA timing, snapshots NUM_SLOTS 16-bit debug values once per frame (tear-free), and for each

---
 rtl/vga_number_scheduler_if.sv | 54 +++++
 rtl/vga_number_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vga_number_scheduler_if.sv
// Bus between the VGA number scheduler and its environment:
// slot inputs, renderer feedback, scan position and sync outputs.
interface vga_number_scheduler_if #(
    parameter int NUM_SLOTS = 4
);
    logic                     pix_en;
    logic [16*NUM_SLOTS-1:0]  slot_values;
    logic [NUM_SLOTS-1:0]     slot_valid;
    logic                     freeze;
    logic                     render_show;
    logic [10:0]              x;
    logic [10:0]              y;
    logic [10:0]              num_center_x;
    logic [10:0]              num_center_y;
    logic [15:0]              num_value;
    logic                     hsync;
    logic                     vsync;
    logic                     pixel_on;
    logic                     frame_tick;

    modport master (
        input  pix_en,
        input  slot_values,
        input  slot_valid,
        input  freeze,
        input  render_show,
        output x,
        output y,
        output num_center_x,
        output num_center_y,
        output num_value,
        output hsync,
        output vsync,
        output pixel_on,
        output frame_tick
    );

    modport slave (
        output pix_en,
        output slot_values,
        output slot_valid,
        output freeze,
        output render_show,
        input  x,
        input  y,
        input  num_center_x,
        input  num_center_y,
        input  num_value,
        input  hsync,
        input  vsync,
        input  pixel_on,
        input  frame_tick
    );
endinterface

// File: rtl/vga_number_scheduler.sv
// VGA scan controller that time-multiplexes one hex-number renderer
// across NUM_SLOTS horizontal bands, with a tear-free per-frame snapshot.
module vga_number_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int ROW_TOP   = 40,
    parameter int ROW_PITCH = 80,
    parameter int CENTER_X  = 320
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_number_scheduler_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SEL_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int LIB_W   = $clog2(ROW_PITCH + 1);

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS     = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS     = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] BAND_TOP  = 11'(ROW_TOP);
    localparam logic [10:0] BAND_END  = 11'(ROW_TOP + NUM_SLOTS * ROW_PITCH);
    localparam logic [10:0] CY_FIRST  = 11'(ROW_TOP + ROW_PITCH / 2);
    localparam logic [10:0] PITCH11   = 11'(ROW_PITCH);
    localparam logic [10:0] CX        = 11'(CENTER_X);
    localparam logic [LIB_W-1:0] LIB_LAST = LIB_W'(ROW_PITCH - 1);

    typedef enum logic {
        BAND_OFF = 1'b0,
        BAND_ON  = 1'b1
    } band_e;

    logic [10:0]                h_cnt;
    logic [10:0]                v_cnt;
    logic [10:0]                h_nxt;
    logic [10:0]                v_nxt;
    logic                       line_wrap;
    logic                       eof;

    band_e                      band_q;
    band_e                      band_d;
    logic [SEL_W-1:0]           sel_q;
    logic [SEL_W-1:0]           sel_d;
    logic [LIB_W-1:0]           lib_q;
    logic [LIB_W-1:0]           lib_d;

    logic [NUM_SLOTS-1:0][15:0] snap_q;
    logic [NUM_SLOTS-1:0]       sval_q;

    logic                       in_band;
    logic                       active;
    logic                       num_enable;
    logic                       hsync_next;
    logic                       vsync_next;

    logic                       hsync_q;
    logic                       vsync_q;
    logic                       pixel_q;
    logic                       tick_q;

    // Next scan position and end-of-line / end-of-frame detection.
    always_comb begin
        line_wrap = (h_cnt == H_LAST);
        eof       = bus.pix_en && line_wrap && (v_cnt == V_LAST);
        h_nxt     = line_wrap ? 11'd0 : h_cnt + 11'd1;
        v_nxt     = v_cnt;
        if (line_wrap) begin
            v_nxt = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end
    end

    // Horizontal and vertical scan counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (bus.pix_en) begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Band tracking: walks bands line by line instead of dividing v_cnt.
    always_comb begin
        band_d = band_q;
        sel_d  = sel_q;
        lib_d  = lib_q;
        if (bus.pix_en && line_wrap) begin
            if (v_nxt == BAND_TOP) begin
                band_d = BAND_ON;
                sel_d  = '0;
                lib_d  = '0;
            end else if (v_nxt == 11'd0 || v_nxt == BAND_END) begin
                band_d = BAND_OFF;
            end else if (band_q == BAND_ON) begin
                if (lib_q == LIB_LAST) begin
                    sel_d = sel_q + SEL_W'(1);
                    lib_d = '0;
                end else begin
                    lib_d = lib_q + LIB_W'(1);
                end
            end
        end
    end

    // Band state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            band_q <= BAND_OFF;
            sel_q  <= '0;
            lib_q  <= '0;
        end else begin
            band_q <= band_d;
            sel_q  <= sel_d;
            lib_q  <= lib_d;
        end
    end

    // Snapshot of slot values taken only at an unfrozen end of frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            snap_q <= '0;
            sval_q <= '0;
        end else if (eof && !bus.freeze) begin
            snap_q <= bus.slot_values;
            sval_q <= bus.slot_valid;
        end
    end

    // Renderer drive and gating for the current scan position.
    always_comb begin
        in_band    = (band_q == BAND_ON);
        active     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        num_enable = active && in_band && sval_q[sel_q];
        hsync_next = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
        vsync_next = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    end

    // Output stage: pixel and syncs stay one pixel tick behind x,y.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            pixel_q <= 1'b0;
        end else if (bus.pix_en) begin
            hsync_q <= hsync_next;
            vsync_q <= vsync_next;
            pixel_q <= num_enable & bus.render_show;
        end
    end

    // Single-clock frame pulse, raised even while frozen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= eof;
        end
    end

    assign bus.x            = h_cnt;
    assign bus.y            = v_cnt;
    assign bus.num_center_x = CX;
    assign bus.num_center_y = in_band ? CY_FIRST + 11'(sel_q) * PITCH11 : 11'd0;
    assign bus.num_value    = in_band ? snap_q[sel_q] : 16'd0;
    assign bus.hsync        = hsync_q;
    assign bus.vsync        = vsync_q;
    assign bus.pixel_on     = pixel_q;
    assign bus.frame_tick   = tick_q;

endmodule
